// File: rtl/scrambler_pkg.sv
// scrambler_pkg: shared LFSR constants and FSM state type for the x^7+x^4+1 scrambler.
package scrambler_pkg;
  localparam int LFSR_W = 7;
  localparam int TAP_HI = 7;
  localparam int TAP_LO = 4;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 7'h7F;
  typedef enum logic {RUN, RECOVER} state_e;
endpackage

// File: rtl/scrambler_bit_step.sv
// scrambler_bit_step: one serial step of the additive scrambler, or a direct seed-recovery shift.
module scrambler_bit_step
  import scrambler_pkg::*;
(
  input  logic [LFSR_W-1:0] i_state,
  input  logic              i_din,
  input  logic              i_recover,
  output logic [LFSR_W-1:0] o_state,
  output logic              o_dout
);
  logic w_fb;
  assign w_fb    = i_state[TAP_HI-1] ^ i_state[TAP_LO-1];
  assign o_state = {i_state[LFSR_W-2:0], i_recover ? i_din : w_fb};
  assign o_dout  = !i_recover && (w_fb ^ i_din);
endmodule

// File: rtl/parallel_scrambler.sv
// parallel_scrambler: DATA_W-bit-per-beat x^7+x^4+1 additive scrambler with one-deep output register.
// Define SCRAMBLER_SEED_RECOVERY_EN to build the descrambler seed-recovery FSM.
module parallel_scrambler
  import scrambler_pkg::*;
#(
  parameter int                DATA_W     = 8,
  parameter logic [LFSR_W-1:0] INIT_STATE = DEFAULT_SEED
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_value,
  input  logic              recover_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sof,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sof,
  output logic              seed_err,
  output logic              recover_done,
  output logic [LFSR_W-1:0] lfsr_state
);
  if (INIT_STATE == '0) begin : g_bad_init
    $error("parallel_scrambler: INIT_STATE must be nonzero");
  end
  if (DATA_W < 1 || DATA_W > 32) begin : g_bad_width
    $error("parallel_scrambler: DATA_W must be 1..32");
  end

  logic [LFSR_W-1:0] r_lfsr;
  logic [DATA_W-1:0] r_data;
  logic              r_valid, r_sof, r_seed_err;
  logic              w_accept;
  logic [LFSR_W-1:0] w_seed, w_start;
  logic [LFSR_W-1:0] w_chain [DATA_W+1];
  logic [DATA_W-1:0] w_dout, w_rec;

  assign in_ready   = !r_valid || out_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_seed     = seed_value == '0 ? DEFAULT_SEED : seed_value;
  // A seed load in the same cycle as a beat seeds that beat's bit chain.
  assign w_start    = seed_load ? w_seed : r_lfsr;
  assign w_chain[0] = w_start;

  for (genvar i = 0; i < DATA_W; i++) begin : g_step
    scrambler_bit_step u_step (
      .i_state  (w_chain[i]),
      .i_din    (in_data[i]),
      .i_recover(w_rec[i]),
      .o_state  (w_chain[i+1]),
      .o_dout   (w_dout[i])
    );
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_lfsr     <= INIT_STATE;
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_sof      <= 1'b0;
      r_seed_err <= 1'b0;
    end else begin
      r_seed_err <= seed_load && seed_value == '0;
      r_lfsr     <= w_accept ? w_chain[DATA_W] : w_start;
      if (w_accept) begin
        r_valid <= 1'b1;
        r_data  <= w_dout;
        r_sof   <= in_sof;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef SCRAMBLER_SEED_RECOVERY_EN
  state_e      r_state;
  logic [2:0]  r_cnt;
  logic        r_rec_done, w_restart, w_rec_on, w_rec_end;
  logic [5:0]  w_cnt0, w_cnt_next;

  assign w_restart  = w_accept && in_sof && recover_mode && !seed_load;
  assign w_rec_on   = w_restart || (r_state == RECOVER && !seed_load);
  assign w_cnt0     = w_restart ? 6'd0 : {3'b000, r_cnt};
  assign w_cnt_next = w_cnt0 + 6'(DATA_W);
  assign w_rec_end  = w_cnt_next >= 6'd7;

  // Only the first 7 bits since the recovering in_sof bypass feedback.
  for (genvar i = 0; i < DATA_W; i++) begin : g_rec
    assign w_rec[i] = w_rec_on && (w_cnt0 + 6'(i) < 6'd7);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state    <= RUN;
      r_cnt      <= '0;
      r_rec_done <= 1'b0;
    end else begin
      r_rec_done <= w_accept && w_rec_on && w_rec_end;
      if (seed_load) begin
        r_state <= RUN;
        r_cnt   <= '0;
      end else if (w_accept && w_rec_on) begin
        r_state <= w_rec_end ? RUN : RECOVER;
        r_cnt   <= w_rec_end ? 3'd0 : w_cnt_next[2:0];
      end
    end
  end

  assign recover_done = r_rec_done;
`else
  logic w_unused;
  assign w_unused     = recover_mode;
  assign w_rec        = '0;
  assign recover_done = 1'b0;
`endif

  assign out_valid  = r_valid;
  assign out_data   = r_data;
  assign out_sof    = r_sof;
  assign seed_err   = r_seed_err;
  assign lfsr_state = r_lfsr;
endmodule

// File: doc/parallel_scrambler.md
PARALLEL_SCRAMBLER -- requirements
Module: parallel_scrambler

Interface
REQ-001 Parameter DATA_W, default 8, bits per beat; legal range 1..32; bit 0 is first in time.
REQ-002 Parameter INIT_STATE, default 7'h7F, LFSR value after reset; a zero value SHALL be an elaboration error.
REQ-003 Clock  input  1  clock; all state updates on rising edge.
REQ-004 Reset  input  1  reset, asynchronous, active-high.
REQ-005 seed_load  input  1  single-cycle request to load seed_value into the LFSR.
REQ-006 seed_value  input  7  seed; bit 6 maps to LFSR stage 7.
REQ-007 recover_mode  input  1  descrambler seed-recovery enable, sampled with each in_sof beat.
REQ-008 in_valid / in_ready  input / output  1 / 1  input handshake.
REQ-009 in_data  input  DATA_W  data beat; in_sof  input  1  first beat of a frame.
REQ-010 out_valid / out_ready  output / input  1 / 1  output handshake.
REQ-011 out_data  output  DATA_W  scrambled beat; out_sof  output  1  forwarded in_sof.
REQ-012 seed_err  output  1  one-cycle pulse: zero seed requested.
REQ-013 recover_done  output  1  one-cycle pulse: seed recovery complete.
REQ-014 lfsr_state  output  7  current LFSR contents, for debug.

Function
REQ-015 Polynomial x^7+x^4+1: per bit, fb = s7^s4; out bit = fb^in bit; state shifts toward s7 with fb entering s1.
REQ-016 Each beat SHALL apply DATA_W sequential bit steps in one cycle; the LFSR advances exactly DATA_W steps per accepted beat.
REQ-017 A beat is accepted when in_valid && in_ready; in_ready = !out_valid || out_ready.
REQ-018 Latency: the output appears on out_data/out_sof with out_valid=1 in the cycle after acceptance.
REQ-019 out_valid clears when out_ready=1 and no new beat is accepted; out_data/out_sof hold while out_valid && !out_ready.
REQ-020 The LFSR SHALL NOT advance when no beat is accepted.
REQ-021 If seed_load coincides with an accepted beat, that beat is processed starting from the loaded seed.
REQ-022 seed_value == 0: load 7'h7F instead and pulse seed_err in the next cycle.
REQ-023 Scramble and descramble are the same operation; no mode port is needed outside recovery.
REQ-024 FSM states RUN and RECOVER. RUN->RECOVER on an accepted in_sof beat with recover_mode=1. RECOVER->RUN after 7 recovered bits, on seed_load, or on Reset.
REQ-025 In RECOVER each input bit shifts directly into s1 (no feedback), and the output bit is 0; the remaining bits of the same beat use normal steps.
REQ-026 Recovery spans ceil(7/DATA_W) beats. recover_done pulses in the cycle after the beat holding the 7th bit.
REQ-027 A new in_sof with recover_mode=1 during RECOVER SHALL restart the 7-bit count from that beat.

Reset
REQ-028 Reset asserted: lfsr=INIT_STATE, FSM=RUN, recovery count=0, and out_valid, out_data, out_sof, seed_err, recover_done all 0.
REQ-029 Reset mid-frame or mid-recovery discards the in-flight output beat; no partial state survives.

Configuration
REQ-030 Macro SCRAMBLER_SEED_RECOVERY_EN defined: REQ-024..REQ-027 are implemented.
REQ-031 Macro absent: the RECOVER state and counter are omitted, recover_mode is ignored, recover_done is tied to 0, and the ports remain.

Structure
REQ-032 Package scrambler_pkg SHALL hold LFSR_W=7, the tap indices (7,4), DEFAULT_SEED=7'h7F, and the FSM state enum.
REQ-033 Sub-module scrambler_bit_step (combinational, one bit: state, din, recover flag -> next state, dout) SHALL be instantiated DATA_W times in a chain.

Verification
REQ-034 DATA_W=8, after reset, in_data=8'h00, one beat -> out_data=8'h70.
REQ-035 127 zero-beats with DATA_W=1 -> output repeats with period 127, and lfsr_state returns to 7'h7F.
REQ-036 Scramble a random frame seeded 7'h5D, then descramble it with a fresh instance seeded 7'h5D -> output equals the original data bit-exact.
REQ-037 seed_load with seed_value=0 -> seed_err pulses once; the next zero beat yields 8'h70.
REQ-038 SCRAMBLER_SEED_RECOVERY_EN, DATA_W=8: a frame scrambled from seed 7'h2A whose first 7 bits are 0, fed with in_sof and recover_mode=1 -> out_data bits 0..6 are 0, recover_done pulses after beat 1, and the rest matches the original.
REQ-039 Hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_data stable, LFSR unchanged; on release, no beat is lost or duplicated.
